// File: rtl/shift_pkg.sv
// Shared types and helpers for the pipelined barrel-shift unit.
package shift_pkg;

  typedef enum logic [1:0] {
    SH_SLL = 2'b00,
    SH_SRL,
    SH_SRA,
    SH_ROL
  } shift_op_t;

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned WORD_AMT_W = 5;

  // Number of register banks for a mux tree of 'levels' levels.
  function automatic int unsigned stages_f(input int unsigned levels, input int unsigned reg_every);
    return (levels + reg_every - 1) / reg_every;
  endfunction

  // Right shifts run through the left-shift tree between two bit reversals.
  function automatic logic is_right_f(input shift_op_t op);
    return (op == SH_SRL) || (op == SH_SRA);
  endfunction

endpackage

// File: rtl/shift_level.sv
// One combinational mux level: left shift by SHIFT when sel, with fill or wrap bits.
module shift_level #(
  parameter int unsigned N     = 64,
  parameter int unsigned SHIFT = 1
) (
  input  logic [N-1:0] data,
  input  logic         sel,
  input  logic         fill_bit,
  input  logic         rotate,
  output logic [N-1:0] shifted
);

  logic [SHIFT-1:0] low;

  always_comb begin
    low     = rotate ? data[N-1 -: SHIFT] : {SHIFT{fill_bit}};
    shifted = sel ? {data[N-SHIFT-1:0], low} : data;
  end

endmodule

// File: rtl/shift_pipe.sv
// Pipelined SLL/SRL/SRA/ROL barrel shifter with RV64 word mode and valid/ready handshake.
module shift_pipe
  import shift_pkg::*;
#(
  parameter int unsigned N         = 64,
  parameter int unsigned REG_EVERY = 2,
  parameter bit          HAS_WORD  = 1'b1,
  parameter int unsigned TAG_W     = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  shift_op_t            in_op,
  input  logic                 in_word,
  input  logic [N-1:0]         in_data,
  input  logic [$clog2(N)-1:0] in_amt,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N-1:0]         out_data,
  output logic [TAG_W-1:0]     out_tag
);

  localparam int unsigned AMT_W   = $clog2(N);
  localparam int unsigned LEVELS  = AMT_W;
  localparam int unsigned STAGES  = stages_f(LEVELS, REG_EVERY);
  localparam bit          WORD_EN = HAS_WORD && (N == 64);

  function automatic logic [N-1:0] rev_f(input logic [N-1:0] x);
    return {<<{x}};
  endfunction

  logic             stall;
  logic [N-1:0]     opnd;
  logic [AMT_W-1:0] amt0;
  logic             word0;
  logic [N-1:0]     flat;
  logic [N-1:0]     fin;

  // Stage inputs (c_*), stage-end data, and register banks (s_*)
  logic             c_valid [STAGES];
  shift_op_t        c_op    [STAGES];
  logic [N-1:0]     c_data  [STAGES];
  logic             c_fill  [STAGES];
  logic [AMT_W-1:0] c_amt   [STAGES];
  logic             c_word  [STAGES];
  logic [TAG_W-1:0] c_tag   [STAGES];
  logic [N-1:0]     e_data  [STAGES];
  logic [N-1:0]     d_next  [STAGES];

  logic             s_valid [STAGES];
  shift_op_t        s_op    [STAGES];
  logic [N-1:0]     s_data  [STAGES];
  logic             s_fill  [STAGES];
  logic [AMT_W-1:0] s_amt   [STAGES];
  logic             s_word  [STAGES];
  logic [TAG_W-1:0] s_tag   [STAGES];

  logic [N-1:0]     lvl_in  [LEVELS];
  logic [N-1:0]     lvl_out [LEVELS];

  assign stall     = out_valid & ~out_ready;
  assign in_ready  = ~stall;
  assign out_valid = s_valid[STAGES-1];
  assign out_data  = s_data[STAGES-1];
  assign out_tag   = s_tag[STAGES-1];

  // Word mode reshapes the low 32 bits so the 64-bit tree produces the 32-bit result.
  if (WORD_EN) begin : g_word
    logic [WORD_W-1:0] lo;
    logic [WORD_W-1:0] wres;

    assign lo    = in_data[WORD_W-1:0];
    assign wres  = flat[WORD_W-1:0];
    assign word0 = in_word;
    assign amt0  = in_word ? {{(AMT_W-WORD_AMT_W){1'b0}}, in_amt[WORD_AMT_W-1:0]} : in_amt;
    assign fin   = c_word[STAGES-1] ? {{(N-WORD_W){wres[WORD_W-1]}}, wres} : flat;

    always_comb begin
      opnd = in_data;
      if (in_word) begin
        unique case (in_op)
          SH_ROL:  opnd = {lo, lo};
          SH_SRA:  opnd = {{(N-WORD_W){lo[WORD_W-1]}}, lo};
          default: opnd = {{(N-WORD_W){1'b0}}, lo};
        endcase
      end
    end
  end else begin : g_full
    logic unused_word;
    assign unused_word = in_word;
    assign opnd        = in_data;
    assign word0       = 1'b0;
    assign amt0        = in_amt;
    assign fin         = flat;
  end

  assign flat = is_right_f(c_op[STAGES-1]) ? rev_f(e_data[STAGES-1]) : e_data[STAGES-1];

  // Stage inputs: stage 0 from the port, later stages from the previous bank.
  for (genvar i = 0; i < int'(STAGES); i++) begin : g_stage
    localparam int unsigned LAST = ((i + 1) * REG_EVERY < LEVELS) ? (i + 1) * REG_EVERY - 1 : LEVELS - 1;

    if (i == 0) begin : g_first
      assign c_valid[i] = in_valid & in_ready;
      assign c_op[i]    = in_op;
      assign c_data[i]  = is_right_f(in_op) ? rev_f(opnd) : opnd;
      assign c_fill[i]  = (in_op == SH_SRA) & opnd[N-1];
      assign c_amt[i]   = amt0;
      assign c_word[i]  = word0;
      assign c_tag[i]   = in_tag;
    end else begin : g_next
      assign c_valid[i] = s_valid[i-1];
      assign c_op[i]    = s_op[i-1];
      assign c_data[i]  = s_data[i-1];
      assign c_fill[i]  = s_fill[i-1];
      assign c_amt[i]   = s_amt[i-1];
      assign c_word[i]  = s_word[i-1];
      assign c_tag[i]   = s_tag[i-1];
    end

    assign e_data[i] = lvl_out[LAST];
    if (i == int'(STAGES) - 1) begin : g_out
      assign d_next[i] = fin;
    end else begin : g_mid
      assign d_next[i] = e_data[i];
    end
  end

  // Level k shifts by 2^k; the first level of each stage reads that stage's input.
  for (genvar k = 0; k < int'(LEVELS); k++) begin : g_level
    localparam int unsigned ST = k / REG_EVERY;

    if (k % REG_EVERY == 0) begin : g_head
      assign lvl_in[k] = c_data[ST];
    end else begin : g_chain
      assign lvl_in[k] = lvl_out[k-1];
    end

    shift_level #(
      .N     (N),
      .SHIFT (1 << k)
    ) u_level (
      .data     (lvl_in[k]),
      .sel      (c_amt[ST][k]),
      .fill_bit (c_fill[ST]),
      .rotate   (c_op[ST] == SH_ROL),
      .shifted  (lvl_out[k])
    );
  end

  // Register banks: all advance together unless the output is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(STAGES); i++) begin
        s_valid[i] <= 1'b0;
        s_op[i]    <= SH_SLL;
        s_data[i]  <= '0;
        s_fill[i]  <= 1'b0;
        s_amt[i]   <= '0;
        s_word[i]  <= 1'b0;
        s_tag[i]   <= '0;
      end
    end else if (!stall) begin
      for (int i = 0; i < int'(STAGES); i++) begin
        s_valid[i] <= c_valid[i];
        s_op[i]    <= c_op[i];
        s_data[i]  <= d_next[i];
        s_fill[i]  <= c_fill[i];
        s_amt[i]   <= c_amt[i];
        s_word[i]  <= c_word[i];
        s_tag[i]   <= c_tag[i];
      end
    end
  end

endmodule

// File: doc/shift_pipe.md
Name: shift_pipe

Overview:
- Pipelined, parametrised barrel-shift unit for the ALU datapath.
- Successor to the single-cycle left-only shifter. It adds:
  - SLL/SRL/SRA/ROL operations;
  - RV64 word-mode (xxxW) ops;
  - configurable register insertion between mux levels;
  - a valid/ready handshake with a pass-through tag.
- Sits between the decode/operand stage and ALU writeback.

Parameters:
- N, 64, data width; power of two, ≥ 8.
- REG_EVERY, 2, mux levels between pipeline registers, 1..$clog2(N).
- HAS_WORD, 1, enables word mode. Legal only when N = 64; forced to 0 otherwise.
- TAG_W, 5, width of the opaque tag carried alongside data.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  unit can accept a beat.
- in_op  in  2  operation (shift_op_t).
- in_word  in  1  word mode; ignored when HAS_WORD = 0.
- in_data  in  N  operand.
- in_amt  in  $clog2(N)  shift amount.
- in_tag  in  TAG_W  tag.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  N  result.
- out_tag  out  TAG_W  tag of the result.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values:
  - all stage valids 0, hence out_valid = 0;
  - out_data = 0, out_tag = 0;
  - in_ready = 1 in the cycle after reset.
- Operations by in_op:
  - 00 SLL: zeros fill from the LSB.
  - 01 SRL: zeros fill from the MSB.
  - 10 SRA: the MSB is replicated.
  - 11 ROL: rotate left; bits leaving the MSB re-enter at the LSB.
- Right shifts: implemented as bit-reverse, left shift, bit-reverse. The fill bit is the SRA sign when op = 10, otherwise 0. ROL selects wrap bits instead of fill.
- Amount: all $clog2(N) bits are used. Amount 0 returns the operand unchanged for every op.
- Word mode (in_word = 1, HAS_WORD = 1):
  - effective amount is in_amt[4:0];
  - the op acts on in_data[31:0] only;
  - result = sign-extension of the 32-bit result to 64 bits;
  - SRAW fills with in_data[31];
  - ROLW rotates within 32 bits;
  - in_data[63:32] never affects the result.
- Pipeline:
  - LEVELS = $clog2(N); STAGES = ceil(LEVELS / REG_EVERY).
  - Level k shifts by 2^k when amt bit k is set, LSB level first.
  - A register bank follows every REG_EVERY levels and the last level.
  - Each bank holds valid, data, op/fill control, remaining amount bits, word flag and tag.
  - Latency: exactly STAGES cycles from accepted input to out_valid, with no stall.
- Handshake and stall:
  - Input is accepted when in_valid & in_ready.
  - Output is consumed when out_valid & out_ready.
  - stall = out_valid & ~out_ready; in_ready = ~stall (combinational).
  - On stall, every bank holds its contents. Bubbles are not collapsed.
  - Without stall, all banks advance every cycle. A bank with valid = 0 still advances (bubble).
  - Full throughput: one result per cycle while out_ready = 1.
- Boundary conditions:
  - Simultaneous accept and consume in a full pipe: legal; throughput is kept.
  - out_data and out_tag stay stable while out_valid = 1 and out_ready = 0.
  - in_valid without in_ready: no state change; the upstream holds its inputs.
  - rst mid-operation: all in-flight beats are dropped; no partial result emerges.
  - HAS_WORD = 0: in_word is ignored; behaviour equals the full-width op.
  - REG_EVERY ≥ LEVELS: single-stage unit, latency 1.

Decomposition:
- Package shift_pkg:
  - shift_op_t enum {SH_SLL = 2'b00, SH_SRL, SH_SRA, SH_ROL};
  - WORD_W = 32 and WORD_AMT_W = 5;
  - function stages_f(levels, reg_every).
- Sub-module shift_level #(N, SHIFT): one combinational mux level with inputs data, sel, fill_bit, rotate and output data. Instantiated LEVELS times in a generate loop; register banks sit in shift_pipe.

Test Plan:
- N=64, REG_EVERY=2 (latency 3), out_ready=1:
  - SLL 0x1 by 63 -> 0x8000000000000000 at cycle 3, out_tag echoes 5'h11.
  - SRA 0x8000000000000000 by 4 -> 0xF800000000000000.
  - SRL same operand by 4 -> 0x0800000000000000.
  - ROL 0x8000000000000001 by 1 -> 0x0000000000000003.
  - Amount 0 for every op -> operand unchanged.
- Word mode:
  - SLLW 0xFFFFFFFF_00000001 by 31 -> 0xFFFFFFFF80000000.
  - SRAW 0x00000000_80000000 by 4 -> 0xFFFFFFFFF8000000.
  - SRLW 0xDEADBEEF_80000000 by 4 -> 0x0000000008000000.
  - amt bit 5 set with SLLW 1 by 33 -> amount 1 -> 0x0000000000000002.
- Back-to-back: 10 consecutive beats with tags 0..9 and out_ready=1 -> 10 results on consecutive cycles 3..12 in tag order.
- Backpressure:
  - hold out_ready=0 for 4 cycles with a full pipe -> in_ready=0, out_data/out_tag stable.
  - on release, results resume with no loss or duplication.
- Reset mid-flight: 3 beats in flight, assert rst for 1 cycle -> out_valid=0 the next cycle, none of the 3 results appear, in_ready=1.
- Parameter sweep:
  - N=16, REG_EVERY=1 (latency 4) and N=32, REG_EVERY=5 (latency 1).
  - Random ops and amounts compared against a reference model; in_word ignored.
